// File: rtl/tlk2711_reg_pkg.sv
// Shared constants and FSM state types for the TLK2711 register bus bridge.
// AXI response codes, register bus widths, write/read FSM encodings.
package tlk2711_reg_pkg;

  localparam int REG_AW = 16;
  localparam int REG_DW = 64;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ISSUE,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } rd_state_t;

endpackage

// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave to single-cycle reg_wen/reg_ren strobe bus; write strobe one cycle after AW+W, read data sampled RD_LATENCY after reg_ren.
// Each channel holds one transaction; AW/W/AR are refused until bready/rready completes the response.
module axil_reg_bridge
  import tlk2711_reg_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 40,
  parameter int RD_LATENCY     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  input  logic [REG_DW-1:0]         s_axil_wdata,
  input  logic [7:0]                s_axil_wstrb,
  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  output logic [1:0]                s_axil_bresp,
  output logic                      s_axil_bvalid,
  input  logic                      s_axil_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  output logic [REG_DW-1:0]         s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  output logic                      s_axil_rvalid,
  input  logic                      s_axil_rready,
  output logic                      o_reg_wen,
  output logic [REG_AW-1:0]         o_reg_waddr,
  output logic [REG_DW-1:0]         o_reg_wdata,
  output logic                      o_reg_ren,
  output logic [REG_AW-1:0]         o_reg_raddr,
  input  logic [REG_DW-1:0]         i_reg_rdata
);

  localparam logic [2:0] LP_RD_LAT = 3'(RD_LATENCY);

  wr_state_t           r_wstate, w_wstate_nxt;
  logic                r_aw_held, r_w_held, w_aw_held_nxt, w_w_held_nxt;
  logic                r_awready, r_wready, w_aw_hs, w_w_hs, w_wr_ok;
  logic [REG_AW-1:0]   r_awaddr;
  logic [REG_DW-1:0]   r_wdata;
  logic [7:0]          r_wstrb;
  logic [1:0]          r_bresp;

  rd_state_t           r_rstate, w_rstate_nxt;
  logic                r_arready, r_ren, r_rerr, w_ar_hs;
  logic [2:0]          r_cnt;
  logic [REG_AW-1:0]   r_raddr;
  logic [REG_DW-1:0]   r_rdata;
  logic [1:0]          r_rresp;

  logic                w_unused;
  assign w_unused = ^{s_axil_awaddr[AXI_ADDR_WIDTH-1:REG_AW], s_axil_araddr[AXI_ADDR_WIDTH-1:REG_AW]};

  always_comb begin
    w_aw_hs       = s_axil_awvalid && r_awready;
    w_w_hs        = s_axil_wvalid && r_wready;
    w_aw_held_nxt = r_aw_held || w_aw_hs;
    w_w_held_nxt  = r_w_held || w_w_hs;
    w_wstate_nxt  = r_wstate;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_held_nxt && w_w_held_nxt) begin
          w_wstate_nxt  = W_ISSUE;
          w_aw_held_nxt = 1'b0;
          w_w_held_nxt  = 1'b0;
        end
      end
      W_ISSUE: w_wstate_nxt = W_RESP;
      W_RESP:  if (s_axil_bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
    // Only full, 8-byte-aligned writes reach the register manager.
    w_wr_ok = (r_awaddr[2:0] == 3'd0) && (r_wstrb == 8'hFF);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_aw_held <= w_aw_held_nxt;
      r_w_held  <= w_w_held_nxt;
      r_awready <= (w_wstate_nxt == W_IDLE) && !w_aw_held_nxt;
      r_wready  <= (w_wstate_nxt == W_IDLE) && !w_w_held_nxt;
      if (w_aw_hs) r_awaddr <= s_axil_awaddr[REG_AW-1:0];
      if (w_w_hs) begin
        r_wdata <= s_axil_wdata;
        r_wstrb <= s_axil_wstrb;
      end
      if (r_wstate == W_ISSUE) r_bresp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_comb begin
    w_ar_hs      = s_axil_arvalid && r_arready;
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_WAIT;
      R_WAIT:  if (r_cnt == 3'd0) w_rstate_nxt = R_RESP;
      R_RESP:  if (s_axil_rready) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_ren     <= 1'b0;
      r_rerr    <= 1'b0;
      r_cnt     <= '0;
      r_raddr   <= '0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= (w_rstate_nxt == R_IDLE);
      r_ren     <= w_ar_hs && (s_axil_araddr[2:0] == 3'd0);
      if (w_ar_hs) begin
        r_raddr <= s_axil_araddr[REG_AW-1:0];
        r_rerr  <= (s_axil_araddr[2:0] != 3'd0);
        r_cnt   <= LP_RD_LAT;
      end else if ((r_rstate == R_WAIT) && (r_cnt != 3'd0)) begin
        r_cnt <= r_cnt - 3'd1;
      end
      // Misaligned reads keep the same latency but never expose register data.
      if ((r_rstate == R_WAIT) && (r_cnt == 3'd0)) begin
        r_rdata <= r_rerr ? '0 : i_reg_rdata;
        r_rresp <= r_rerr ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign s_axil_awready = r_awready;
  assign s_axil_wready  = r_wready;
  assign s_axil_bvalid  = (r_wstate == W_RESP);
  assign s_axil_bresp   = r_bresp;
  assign o_reg_wen      = (r_wstate == W_ISSUE) && w_wr_ok;
  assign o_reg_waddr    = r_awaddr;
  assign o_reg_wdata    = r_wdata;

  assign s_axil_arready = r_arready;
  assign s_axil_rvalid  = (r_rstate == R_RESP);
  assign s_axil_rdata   = r_rdata;
  assign s_axil_rresp   = r_rresp;
  assign o_reg_ren      = r_ren;
  assign o_reg_raddr    = r_raddr;

endmodule

// File: doc/axil_reg_bridge.md
# axil_reg_bridge

AXI4-Lite slave that converts PS master-port register accesses into the single-cycle `reg_wen`/`reg_ren` strobe bus consumed by the TLK2711 register manager. It sits directly upstream of the register manager: the write side drives its write strobe/address/data, and the read side pulses its read strobe and samples its registered read data after a fixed latency. Write and read channels run independently, each with its own state machine.

## Interface
Parameters:
- `AXI_ADDR_WIDTH`, 40: width of AXI byte address; only bits [15:0] forwarded.
- `RD_LATENCY`, 1: clocks from `o_reg_ren` pulse to valid `i_reg_rdata` (range 1..7).

Ports:
- `clk` in 1: single clock for AXI and register bus.
- `rst` in 1: asynchronous, active-high reset.
- `s_axil_awaddr` in AXI_ADDR_WIDTH, `s_axil_awvalid` in 1, `s_axil_awready` out 1: write address channel.
- `s_axil_wdata` in 64, `s_axil_wstrb` in 8, `s_axil_wvalid` in 1, `s_axil_wready` out 1: write data channel.
- `s_axil_bresp` out 2, `s_axil_bvalid` out 1, `s_axil_bready` in 1: write response.
- `s_axil_araddr` in AXI_ADDR_WIDTH, `s_axil_arvalid` in 1, `s_axil_arready` out 1: read address.
- `s_axil_rdata` out 64, `s_axil_rresp` out 2, `s_axil_rvalid` out 1, `s_axil_rready` in 1: read data.
- `o_reg_wen` out 1: one-cycle write strobe.
- `o_reg_waddr` out 16, `o_reg_wdata` out 64: valid while `o_reg_wen` high.
- `o_reg_ren` out 1: one-cycle read strobe.
- `o_reg_raddr` out 16: valid while `o_reg_ren` high.
- `i_reg_rdata` in 64: register read data.

## Operation
- Reset values: all ready/valid/strobe outputs 0, `bresp`/`rresp` 0, `rdata`/`waddr`/`wdata`/`raddr` 0, both FSMs idle.
- Write FSM states: W_IDLE, W_ISSUE, W_RESP.
  - W_IDLE: `awready`=1 until AW captured, `wready`=1 until W captured; AW and W may arrive in any order or the same cycle. Once both are held, go to W_ISSUE.
  - W_ISSUE (1 cycle): if `awaddr[2:0]`==0 and `wstrb`==8'hFF, pulse `o_reg_wen` with `awaddr[15:0]`/`wdata` and set `bresp`=OKAY (00); otherwise no strobe and `bresp`=SLVERR (10). Go to W_RESP.
  - W_RESP: `bvalid`=1 until `bready`, then W_IDLE. No AW/W is accepted while not idle.
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: `arready`=1. On handshake, latch address, pulse `o_reg_ren` in the next cycle (entering R_WAIT), and load a 3-bit counter with RD_LATENCY.
  - R_WAIT: decrement the counter each clock; at 0, capture `i_reg_rdata` into `rdata` and go to R_RESP. A misaligned address (`araddr[2:0]`≠0) suppresses `o_reg_ren`, returns `rdata`=0 with `rresp`=SLVERR, and still takes the same latency.
  - R_RESP: `rvalid`=1 with stable data until `rready`, then R_IDLE.
- Read and write operate concurrently; `o_reg_wen` and `o_reg_ren` may be high in the same cycle.
- Address bits above [15:0] are ignored (aliasing is accepted).

## Timing
- Write: AW+W handshake cycle N → `o_reg_wen` at N+1 → `bvalid` from N+2.
- Read: AR handshake at N → `o_reg_ren` at N+1 → data sampled at N+1+RD_LATENCY → `rvalid` from N+2+RD_LATENCY.
- Throughput: at most one write per 3 cycles and one read per 3+RD_LATENCY cycles.
- Asserting `rst` mid-transaction aborts it asynchronously: strobes drop immediately and no response is issued. The master must be reset with the bridge.
- `bvalid`/`rvalid` never deassert without the matching ready.

## Structure
- Shared package `tlk2711_reg_pkg`: AXI response constants (OKAY=2'b00, SLVERR=2'b10), register address width (16), data width (64), and the write/read FSM state enums.
- No sub-module; the two FSMs live in one file.

## Test plan
- AW then W 3 cycles later, addr 0x0108, data 0x0000_0000_8000_0000, wstrb 0xFF → one `o_reg_wen` pulse with waddr 0x0108; `bresp`=00.
- W before AW, with `bready` held low 5 cycles → `bvalid` held 5 cycles, single `wen` pulse, no new AW accepted until B handshake.
- Read 0x0100, RD_LATENCY=1, `i_reg_rdata`=0x2000_0000_0012_0366 one cycle after `ren` → `rdata` matches, `rresp`=00, `rvalid` 3 cycles after AR.
- wstrb 0x0F or awaddr 0x0104 → no `o_reg_wen`, `bresp`=SLVERR; araddr 0x0103 → no `o_reg_ren`, `rdata`=0, `rresp`=SLVERR.
- Simultaneous write 0x0010 and read 0x0120 → `wen` and `ren` in the same cycle, both responses correct.
- `rst` asserted during R_WAIT → `rvalid`/`o_reg_ren` 0 immediately; a following read completes normally.
